// File: rtl/demosaic_mul_arb_pkg.sv
// Shared widths, defaults and helpers for the demosaic multiplier arbiter.
// Product range limits describe the exact signed x unsigned output span.
package demosaic_mul_arb_pkg;

  localparam int DEF_NUM_REQ    = 4;
  localparam int DEF_A_WIDTH    = 9;
  localparam int DEF_B_WIDTH    = 18;
  localparam int DEF_P_WIDTH    = DEF_A_WIDTH + DEF_B_WIDTH;
  localparam int DEF_MUL_STAGES = 2;
  localparam int DEF_ID_WIDTH   = 2;

  localparam int MAX_REQ = 8;

  // Extremes: -256 * 262143 and 255 * 262143.
  localparam logic signed [DEF_P_WIDTH-1:0] P_MIN = -27'sd67108608;
  localparam logic signed [DEF_P_WIDTH-1:0] P_MAX = 27'sd66846465;

  function automatic int onehot_to_idx(input logic [MAX_REQ-1:0] oh);
    int idx;
    idx = 0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (oh[i]) idx = idx | i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/demosaic_mul_pipe.sv
// MUL_STAGES-deep signed x unsigned multiplier with valid/id sideband, advanced by adv.
// Latency MUL_STAGES; adv=0 freezes every stage so a held output stays stable.
module demosaic_mul_pipe
  import demosaic_mul_arb_pkg::*;
#(
  parameter int A_WIDTH    = DEF_A_WIDTH,
  parameter int B_WIDTH    = DEF_B_WIDTH,
  parameter int P_WIDTH    = DEF_P_WIDTH,
  parameter int MUL_STAGES = DEF_MUL_STAGES,
  parameter int ID_WIDTH   = DEF_ID_WIDTH
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                adv,
  input  logic                in_vld,
  input  logic [A_WIDTH-1:0]  in_a,
  input  logic [B_WIDTH-1:0]  in_b,
  input  logic [ID_WIDTH-1:0] in_id,
  output logic                out_vld,
  output logic [ID_WIDTH-1:0] out_id,
  output logic [P_WIDTH-1:0]  out_p,
  output logic                busy
);

  function automatic logic signed [P_WIDTH-1:0] mul(input logic [A_WIDTH-1:0] a,
                                                   input logic [B_WIDTH-1:0] b);
    logic signed [P_WIDTH-1:0] ax;
    logic signed [P_WIDTH-1:0] bx;
    ax = P_WIDTH'($signed(a));
    bx = P_WIDTH'($signed({1'b0, b}));
    return ax * bx;
  endfunction

  logic [MUL_STAGES-1:0] vld_q, vld_d;
  logic [ID_WIDTH-1:0]   id_q [MUL_STAGES];
  logic [ID_WIDTH-1:0]   id_d [MUL_STAGES];

  always_comb begin
    vld_d = vld_q;
    id_d  = id_q;
    if (adv) begin
      vld_d[0] = in_vld;
      id_d[0]  = in_id;
      for (int s = 1; s < MUL_STAGES; s++) begin
        vld_d[s] = vld_q[s-1];
        id_d[s]  = id_q[s-1];
      end
    end
  end

  // Only valid bits and the visible output stage are cleared; inner data is don't-care.
  always_ff @(posedge clk) begin
    id_q <= id_d;
    if (!rst_n) begin
      vld_q              <= '0;
      id_q[MUL_STAGES-1] <= '0;
    end else begin
      vld_q <= vld_d;
    end
  end

  generate
    if (MUL_STAGES == 1) begin : g_direct
      logic signed [P_WIDTH-1:0] p_q, p_d;

      always_comb begin
        p_d = p_q;
        if (adv) p_d = mul(in_a, in_b);
      end

      always_ff @(posedge clk) begin
        if (!rst_n) p_q <= '0;
        else        p_q <= p_d;
      end

      assign out_p = p_q;
    end else begin : g_staged
      logic [A_WIDTH-1:0]        a_q, a_d;
      logic [B_WIDTH-1:0]        b_q, b_d;
      logic signed [P_WIDTH-1:0] p_q [MUL_STAGES-1];
      logic signed [P_WIDTH-1:0] p_d [MUL_STAGES-1];

      always_comb begin
        a_d = a_q;
        b_d = b_q;
        p_d = p_q;
        if (adv) begin
          a_d    = in_a;
          b_d    = in_b;
          p_d[0] = mul(a_q, b_q);
          for (int s = 1; s < MUL_STAGES - 1; s++) p_d[s] = p_q[s-1];
        end
      end

      always_ff @(posedge clk) begin
        a_q <= a_d;
        b_q <= b_d;
        p_q <= p_d;
        if (!rst_n) p_q[MUL_STAGES-2] <= '0;
      end

      assign out_p = p_q[MUL_STAGES-2];
    end
  endgenerate

  assign out_vld = vld_q[MUL_STAGES-1];
  assign out_id  = id_q[MUL_STAGES-1];
  assign busy    = |vld_q;

endmodule

// File: rtl/demosaic_mul_arbiter.sv
// Round-robin arbiter sharing one signed x unsigned multiplier among NUM_REQ requesters.
// Result MUL_STAGES cycles after accept; a held result freezes the pipe and drops all req_ready.
module demosaic_mul_arbiter
  import demosaic_mul_arb_pkg::*;
#(
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int A_WIDTH    = DEF_A_WIDTH,
  parameter int B_WIDTH    = DEF_B_WIDTH,
  parameter int P_WIDTH    = DEF_P_WIDTH,
  parameter int MUL_STAGES = DEF_MUL_STAGES,
  parameter int ID_WIDTH   = DEF_ID_WIDTH
) (
  input  logic                       ap_clk,
  input  logic                       ap_rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*A_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*B_WIDTH-1:0] req_b,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [ID_WIDTH-1:0]        res_id,
  output logic [P_WIDTH-1:0]         res_p,
  output logic                       busy
);

  logic                adv;
  logic                accept;
  logic [ID_WIDTH-1:0] ptr_q, ptr_d;
  logic [ID_WIDTH-1:0] grant_idx;
  logic [NUM_REQ-1:0]  grant_oh;
  logic [MAX_REQ-1:0]  grant_ext;
  logic [A_WIDTH-1:0]  sel_a;
  logic [B_WIDTH-1:0]  sel_b;

  assign adv = !(res_valid && !res_ready);

  // Search starts just past the last winner so every active requester gets a turn.
  always_comb begin
    logic found;
    int   cand;
    grant_oh = '0;
    found    = 1'b0;
    cand     = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = int'(ptr_q) + k;
      if (cand >= NUM_REQ) cand -= NUM_REQ;
      if (!found && req_valid[cand]) begin
        grant_oh[cand] = 1'b1;
        found          = 1'b1;
      end
    end
  end

  always_comb begin
    grant_ext                = '0;
    grant_ext[NUM_REQ-1:0]   = grant_oh;
    grant_idx                = ID_WIDTH'(onehot_to_idx(grant_ext));
    req_ready                = adv ? grant_oh : '0;
    accept                   = |(req_valid & req_ready);
    sel_a                    = req_a[int'(grant_idx)*A_WIDTH +: A_WIDTH];
    sel_b                    = req_b[int'(grant_idx)*B_WIDTH +: B_WIDTH];
    ptr_d                    = ptr_q;
    if (accept) ptr_d = grant_idx;
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) ptr_q <= ID_WIDTH'(NUM_REQ - 1);
    else           ptr_q <= ptr_d;
  end

  demosaic_mul_pipe #(
    .A_WIDTH    (A_WIDTH),
    .B_WIDTH    (B_WIDTH),
    .P_WIDTH    (P_WIDTH),
    .MUL_STAGES (MUL_STAGES),
    .ID_WIDTH   (ID_WIDTH)
  ) u_pipe (
    .clk     (ap_clk),
    .rst_n   (ap_rst_n),
    .adv     (adv),
    .in_vld  (accept),
    .in_a    (sel_a),
    .in_b    (sel_b),
    .in_id   (grant_idx),
    .out_vld (res_valid),
    .out_id  (res_id),
    .out_p   (res_p),
    .busy    (busy)
  );

endmodule

// File: tb/tb_demosaic_mul_arbiter.sv
// Directed bench for demosaic_mul_arbiter: inputs driven on the falling edge,
// outputs checked 1ns later with immediate assertions.
module tb_demosaic_mul_arbiter;
  import demosaic_mul_arb_pkg::*;

  logic               ap_clk;
  logic               ap_rst_n;
  logic [3:0]         req_valid;
  logic [3:0]         req_ready;
  logic [4*9-1:0]     req_a;
  logic [4*18-1:0]    req_b;
  logic               res_valid;
  logic               res_ready;
  logic [1:0]         res_id;
  logic signed [26:0] res_p;
  logic               busy;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Products of the base operand table: 1*10, -2*20, 3*30, -4*40.
  int prod_tab [4] = '{10, -40, 90, -160};

  demosaic_mul_arbiter dut (
    .ap_clk    (ap_clk),
    .ap_rst_n  (ap_rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_id    (res_id),
    .res_p     (res_p),
    .busy      (busy)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
  endtask

  task automatic set_op(input int i, input logic signed [8:0] a, input logic [17:0] b);
    req_a[i*9 +: 9]   = a;
    req_b[i*18 +: 18] = b;
  endtask

  task automatic load_table();
    set_op(0, 9'sd1, 18'd10);
    set_op(1, -9'sd2, 18'd20);
    set_op(2, 9'sd3, 18'd30);
    set_op(3, -9'sd4, 18'd40);
  endtask

  task automatic chk_res(input string tag, input logic [1:0] id, input int p);
    chk({tag, ".valid"}, 32'(res_valid), 32'd1);
    chk({tag, ".id"}, 32'(res_id), 32'(id));
    chk({tag, ".p"}, 32'(res_p), p);
  endtask

  task automatic cyc();
    @(negedge ap_clk);
  endtask

  initial begin
    ap_rst_n  = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    res_ready = 1'b1;
    cyc();
    cyc();
    #1;
    chk("rst.res_valid", 32'(res_valid), 32'd0);
    chk("rst.res_id", 32'(res_id), 32'd0);
    chk("rst.res_p", 32'(res_p), 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.req_ready", 32'(req_ready), 32'd0);
    cyc();
    ap_rst_n = 1'b1;
    load_table();

    // All four requesting: rotation from requester 0, results two cycles behind.
    for (int c = 0; c < 8; c++) begin
      if (c > 0) cyc();
      req_valid = (c < 5) ? 4'hF : 4'h0;
      #1;
      chk($sformatf("rr.c%0d.ready", c), 32'(req_ready), (c < 5) ? (32'd1 << (c % 4)) : 32'd0);
      if (c >= 2 && c <= 6)
        chk_res($sformatf("rr.c%0d", c), 2'((c - 2) % 4), prod_tab[(c - 2) % 4]);
    end
    chk("rr.drain.valid", 32'(res_valid), 32'd0);

    // Extreme operands through requester 1, back to back.
    cyc(); req_valid = 4'b0010; set_op(1, -9'sd256, 18'd262143); #1;
    chk("ext.c0.ready", 32'(req_ready), 32'b0010);
    cyc(); set_op(1, 9'sd255, 18'd262143); #1;
    chk("ext.c1.ready", 32'(req_ready), 32'b0010);
    cyc(); set_op(1, 9'sd0, 18'd12345); #1;
    chk_res("ext.min", 2'd1, 32'(P_MIN));
    cyc(); req_valid = 4'b0000; #1;
    chk_res("ext.max", 2'd1, 32'(P_MAX));
    cyc(); #1;
    chk_res("ext.zero", 2'd1, 0);

    // Single request from requester 0.
    cyc(); req_valid = 4'b0001; set_op(0, -9'sd3, 18'd1000); #1;
    chk("single.ready", 32'(req_ready), 32'b0001);
    cyc(); req_valid = 4'b0000; #1;
    chk("single.ready_off", 32'(req_ready), 32'd0);
    chk("single.busy", 32'(busy), 32'd1);
    chk("single.early", 32'(res_valid), 32'd0);
    cyc(); #1;
    chk_res("single", 2'd0, -3000);
    cyc(); #1;
    chk("single.after", 32'(res_valid), 32'd0);
    chk("single.idle", 32'(busy), 32'd0);

    // Backpressure: pointer at 0, so grants run 1, 2, then stall for 3 cycles.
    load_table();
    cyc(); req_valid = 4'hF; #1;
    chk("bp.c0.ready", 32'(req_ready), 32'b0010);
    cyc(); #1;
    chk("bp.c1.ready", 32'(req_ready), 32'b0100);
    for (int s = 0; s < 3; s++) begin
      cyc(); res_ready = 1'b0; #1;
      chk($sformatf("bp.stall%0d.ready", s), 32'(req_ready), 32'd0);
      chk_res($sformatf("bp.stall%0d", s), 2'd1, -40);
      chk($sformatf("bp.stall%0d.busy", s), 32'(busy), 32'd1);
    end
    cyc(); res_ready = 1'b1; #1;
    chk("bp.release.ready", 32'(req_ready), 32'b1000);
    chk_res("bp.release", 2'd1, -40);
    cyc(); req_valid = 4'h0; #1;
    chk_res("bp.r1", 2'd2, 90);
    cyc(); #1;
    chk_res("bp.r2", 2'd3, -160);
    cyc(); #1;
    chk("bp.drain", 32'(res_valid), 32'd0);

    // Fairness: requester 2 wins alone, then 3 beats 0, then 0.
    cyc(); req_valid = 4'b0100; #1;
    chk("fair.c0.ready", 32'(req_ready), 32'b0100);
    cyc(); req_valid = 4'b1001; #1;
    chk("fair.c1.ready", 32'(req_ready), 32'b1000);
    cyc(); #1;
    chk("fair.c2.ready", 32'(req_ready), 32'b0001);
    chk_res("fair.r0", 2'd2, 90);
    cyc(); req_valid = 4'b0000; #1;
    chk_res("fair.r1", 2'd3, -160);
    cyc(); #1;
    chk_res("fair.r2", 2'd0, 10);

    // Reset with two products in flight.
    cyc(); req_valid = 4'b0011; #1;
    chk("mrst.c0.ready", 32'(req_ready), 32'b0010);
    cyc(); #1;
    chk("mrst.c1.ready", 32'(req_ready), 32'b0001);
    cyc(); req_valid = 4'b0000; ap_rst_n = 1'b0; #1;
    chk_res("mrst.inflight", 2'd1, -40);
    cyc(); ap_rst_n = 1'b1; #1;
    chk("mrst.res_valid", 32'(res_valid), 32'd0);
    chk("mrst.busy", 32'(busy), 32'd0);
    chk("mrst.res_p", 32'(res_p), 32'd0);
    req_valid = 4'hF; #1;
    chk("mrst.first_grant", 32'(req_ready), 32'b0001);
    cyc(); req_valid = 4'h0; #1;
    chk("mrst.no_ghost", 32'(res_valid), 32'd0);
    cyc(); #1;
    chk_res("mrst.r0", 2'd0, 10);
    cyc(); #1;
    chk("mrst.idle", 32'(busy), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
